// File: rtl/mux32_arb_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | mux32_arb_if : two-source / one-sink beat channel bundle for the     |
// |                packet round-robin arbiter.                           |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
interface mux32_arb_if #(
    parameter int WIDTH = 32
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_last;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_last;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             sel;
    logic             busy;

    modport master (
        output in0_valid, in0_data, in0_last,
        input  in0_ready,
        output in1_valid, in1_data, in1_last,
        input  in1_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  sel, busy
    );

    modport slave (
        input  in0_valid, in0_data, in0_last,
        output in0_ready,
        input  in1_valid, in1_data, in1_last,
        output in1_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output sel, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux32_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | mux32_arb : packet-level round-robin arbiter sharing one registered  |
// |             32-bit result channel between two sources.               |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module mux32_arb #(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    mux32_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY0 = 2'd1,
        S_BUSY1 = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_data;

    logic             w_sel;
    logic             w_busy;
    logic             w_space;
    logic             w_mux_valid;
    logic             w_mux_last;
    logic             w_load;
    logic [WIDTH-1:0] w_mux_data;

    assign w_sel   = (r_state == S_BUSY1);
    assign w_busy  = (r_state != S_IDLE);
    assign w_space = !r_out_valid || bus.out_ready;

    // Bit-level AND-OR selection, matching the shared gate-level 2:1 mux.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_mux
            assign w_mux_data[i] = (bus.in0_data[i] & ~w_sel) | (bus.in1_data[i] & w_sel);
        end
    endgenerate

    assign w_mux_valid = w_sel ? bus.in1_valid : bus.in0_valid;
    assign w_mux_last  = w_sel ? bus.in1_last  : bus.in0_last;
    assign w_load      = w_busy && w_mux_valid && w_space;

    assign bus.in0_ready = (r_state == S_BUSY0) && w_space;
    assign bus.in1_ready = (r_state == S_BUSY1) && w_space;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.sel       = w_sel;
    assign bus.busy      = w_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // On a tie the source that did not finish last wins.
                    if (bus.in0_valid && bus.in1_valid)
                        r_state <= r_last_grant ? S_BUSY0 : S_BUSY1;
                    else if (bus.in0_valid)
                        r_state <= S_BUSY0;
                    else if (bus.in1_valid)
                        r_state <= S_BUSY1;
                end
                S_BUSY0, S_BUSY1: begin
                    if (w_load && w_mux_last) begin
                        r_state      <= S_IDLE;
                        r_last_grant <= w_sel;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_last  <= w_mux_last;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire
